// File: rtl/gate_event_sequencer.sv
// Gate sensor front-end: synchronise, debounce, queue one request per direction and issue
// spaced single-cycle entry/exit pulses to the parking FSM.
module gate_event_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned SPACING         = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor_raw,
  input  logic       exit_sensor_raw,
  input  logic [1:0] exit_slot_raw,
  input  logic       is_full,
  input  logic [3:0] spots,
  output logic       entry_signal,
  output logic       exit_signal,
  output logic [1:0] exit_slot,
  output logic       rejected,
  output logic       overrun
);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  localparam int unsigned GapW = $clog2(SPACING + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GapW-1:0]  GapLoad = GapW'(SPACING);

  logic entry_s1, entry_s2, exit_s1, exit_s2;
  logic [1:0] slot_s1, slot_s2;
  logic [CNT_W-1:0] entry_cnt, exit_cnt;
  logic entry_filt, exit_filt, entry_filt_prev, exit_filt_prev;
  logic entry_pend, exit_pend;
  logic [1:0] slot_q;
  logic entry_rise, exit_rise;
  logic clr_entry, clr_exit;
  logic entry_d, exit_d, rejected_d;
  logic [1:0] exit_slot_d;
  state_e state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;

  // Synchronisers and debounce filters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_s1 <= 1'b0;
      entry_s2 <= 1'b0;
      exit_s1  <= 1'b0;
      exit_s2  <= 1'b0;
      slot_s1  <= 2'b00;
      slot_s2  <= 2'b00;
      entry_cnt <= '0;
      exit_cnt  <= '0;
      entry_filt <= 1'b0;
      exit_filt  <= 1'b0;
      entry_filt_prev <= 1'b0;
      exit_filt_prev  <= 1'b0;
    end else begin
      entry_s1 <= entry_sensor_raw;
      entry_s2 <= entry_s1;
      exit_s1  <= exit_sensor_raw;
      exit_s2  <= exit_s1;
      slot_s1  <= exit_slot_raw;
      slot_s2  <= slot_s1;
      entry_filt_prev <= entry_filt;
      exit_filt_prev  <= exit_filt;
      if (entry_s2 == entry_filt) begin
        entry_cnt <= '0;
      end else if (entry_cnt == CntLast) begin
        entry_filt <= entry_s2;
        entry_cnt  <= '0;
      end else begin
        entry_cnt <= entry_cnt + 1'b1;
      end
      if (exit_s2 == exit_filt) begin
        exit_cnt <= '0;
      end else if (exit_cnt == CntLast) begin
        exit_filt <= exit_s2;
        exit_cnt  <= '0;
      end else begin
        exit_cnt <= exit_cnt + 1'b1;
      end
    end
  end

  assign entry_rise = entry_filt & ~entry_filt_prev;
  assign exit_rise  = exit_filt & ~exit_filt_prev;

  // A rise while already pending is dropped; the slot of the queued exit is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_pend <= 1'b0;
      exit_pend  <= 1'b0;
      slot_q     <= 2'b00;
      overrun    <= 1'b0;
    end else begin
      entry_pend <= (entry_pend & ~clr_entry) | (entry_rise & ~entry_pend);
      exit_pend  <= (exit_pend & ~clr_exit) | (exit_rise & ~exit_pend);
      if (exit_rise && !exit_pend) slot_q <= slot_s2;
      overrun <= (entry_rise & entry_pend) | (exit_rise & exit_pend);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      gap_q        <= '0;
      entry_signal <= 1'b0;
      exit_signal  <= 1'b0;
      exit_slot    <= 2'b00;
      rejected     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      entry_signal <= entry_d;
      exit_signal  <= exit_d;
      exit_slot    <= exit_slot_d;
      rejected     <= rejected_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if ((exit_pend && spots[slot_q]) || (!exit_pend && entry_pend && !is_full)) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StGap;
        gap_d   = GapLoad;
      end
      StGap: begin
        gap_d = gap_q - 1'b1;
        if (gap_q <= GapW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    entry_d     = 1'b0;
    exit_d      = 1'b0;
    rejected_d  = 1'b0;
    exit_slot_d = exit_slot;
    clr_entry   = 1'b0;
    clr_exit    = 1'b0;
    if (state_q == StIdle) begin
      if (exit_pend) begin
        clr_exit = 1'b1;
        if (spots[slot_q]) begin
          exit_d      = 1'b1;
          exit_slot_d = slot_q;
        end else begin
          rejected_d = 1'b1;
        end
      end else if (entry_pend && !is_full) begin
        entry_d   = 1'b1;
        clr_entry = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gate_event_sequencer.sv
// Self-checking bench: directed gate scenarios plus random sensor traffic against a
// cycle-level reference model built from the request/arbitration rules.
module tb_gate_event_sequencer;
  localparam int D = 4;
  localparam int SP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic entry_raw = 1'b0, exit_raw = 1'b0;
  logic [1:0] slot_raw = 2'd0;
  logic is_full = 1'b0;
  logic [3:0] spots = 4'd0;
  logic entry_signal, exit_signal, rejected, overrun;
  logic [1:0] exit_slot;

  gate_event_sequencer #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .SPACING(SP)) dut (
    .clk(clk), .reset(reset), .entry_sensor_raw(entry_raw), .exit_sensor_raw(exit_raw),
    .exit_slot_raw(slot_raw), .is_full(is_full), .spots(spots),
    .entry_signal(entry_signal), .exit_signal(exit_signal), .exit_slot(exit_slot),
    .rejected(rejected), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: delay lines, run-length debounce, request flags, and an
  // "earliest edge for the next pulse" in place of an issuer state machine.
  int m_edge = 0, m_next_ok = 0, m_erun, m_xrun;
  logic m_es[2], m_xs[2];
  logic [1:0] m_ss[2];
  logic m_ef, m_xf, m_efp, m_xfp, m_ep, m_xp;
  logic [1:0] m_slot, m_xslot;
  logic m_entry, m_exit, m_rej, m_ovr;

  task automatic model_clear();
    m_es = '{1'b0, 1'b0}; m_xs = '{1'b0, 1'b0}; m_ss = '{2'd0, 2'd0};
    m_erun = 0; m_xrun = 0;
    m_ef = 0; m_xf = 0; m_efp = 0; m_xfp = 0; m_ep = 0; m_xp = 0;
    m_slot = 0; m_xslot = 0; m_entry = 0; m_exit = 0; m_rej = 0; m_ovr = 0;
    m_next_ok = 0;
  endtask

  task automatic debounce(input logic s, inout logic f, inout int run);
    run = (s != f) ? run + 1 : 0;
    if (run == D) begin
      f = s;
      run = 0;
    end
  endtask

  task automatic model_step();
    logic rise_e, rise_x, clr_e, clr_x;
    m_edge++;
    if (reset) begin
      model_clear();
      return;
    end
    rise_e = m_ef && !m_efp;
    rise_x = m_xf && !m_xfp;
    m_entry = 0; m_exit = 0; m_rej = 0; clr_e = 0; clr_x = 0;
    if (m_edge >= m_next_ok) begin
      if (m_xp && spots[m_slot]) begin
        m_exit = 1; m_xslot = m_slot; clr_x = 1; m_next_ok = m_edge + SP + 2;
      end else if (m_xp) begin
        m_rej = 1; clr_x = 1;
      end else if (m_ep && !is_full) begin
        m_entry = 1; clr_e = 1; m_next_ok = m_edge + SP + 2;
      end
    end
    m_ovr = (rise_e && m_ep) || (rise_x && m_xp);
    if (rise_x && !m_xp) m_slot = m_ss[1];
    m_ep = (m_ep && !clr_e) || (rise_e && !m_ep);
    m_xp = (m_xp && !clr_x) || (rise_x && !m_xp);
    m_efp = m_ef;
    m_xfp = m_xf;
    debounce(m_es[1], m_ef, m_erun);
    debounce(m_xs[1], m_xf, m_xrun);
    m_es[1] = m_es[0]; m_es[0] = entry_raw;
    m_xs[1] = m_xs[0]; m_xs[0] = exit_raw;
    m_ss[1] = m_ss[0]; m_ss[0] = slot_raw;
  endtask

  // Per-scenario bookkeeping: tick index of first pulse and pulse counts
  int tick_no, entry_at, exit_at, rej_at, n_entry, n_exit, n_ovr;
  logic [1:0] first_slot;

  task automatic mark();
    tick_no = 0; entry_at = -1; exit_at = -1; rej_at = -1;
    n_entry = 0; n_exit = 0; n_ovr = 0; first_slot = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tick_no++;
    check_eq("entry_signal", entry_signal, m_entry);
    check_eq("exit_signal", exit_signal, m_exit);
    check_eq("rejected", rejected, m_rej);
    check_eq("overrun", overrun, m_ovr);
    check_eq("exit_slot", exit_slot, m_xslot);
    if (entry_signal) begin
      n_entry++;
      if (entry_at < 0) entry_at = tick_no;
    end
    if (exit_signal) begin
      n_exit++;
      if (exit_at < 0) begin
        exit_at = tick_no;
        first_slot = exit_slot;
      end
    end
    if (rejected && rej_at < 0) rej_at = tick_no;
    if (overrun) n_ovr++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    entry_raw = 0; exit_raw = 0; slot_raw = 0; is_full = 0; spots = 0;
    ticks(2);
    reset = 1'b0;
    ticks(3);
  endtask

  initial begin
    model_clear();
    mark();
    ticks(2);
    check_eq("reset_entry", entry_signal, 1'b0);
    check_eq("reset_exit", exit_signal, 1'b0);
    check_eq("reset_slot", exit_slot, 2'd0);
    reset = 1'b0;
    ticks(2);

    // Clean entry: single pulse 7 edges after the sampling edge (8th tick)
    mark();
    entry_raw = 1;
    ticks(12);
    entry_raw = 0;
    ticks(10);
    check_eq("t1_latency", 8'(entry_at), 8'd8);
    check_eq("t1_count", 8'(n_entry), 8'd1);
    check_eq("t1_no_exit", 8'(n_exit + (rej_at >= 0 ? 1 : 0)), 8'd0);

    // Bouncing entry never settles
    do_reset();
    mark();
    for (int i = 0; i < 8; i++) begin
      entry_raw = ~entry_raw;
      ticks(2);
    end
    entry_raw = 0;
    ticks(12);
    check_eq("t2_no_entry", 8'(n_entry), 8'd0);
    check_eq("t2_no_overrun", 8'(n_ovr), 8'd0);

    // Simultaneous entry and exit: exit first, entry 4 cycles later
    do_reset();
    mark();
    spots = 4'b0100; slot_raw = 2'd2;
    entry_raw = 1; exit_raw = 1;
    ticks(10);
    entry_raw = 0; exit_raw = 0;
    ticks(10);
    check_eq("t3_exit_at", 8'(exit_at), 8'd8);
    check_eq("t3_exit_slot", first_slot, 2'd2);
    check_eq("t3_entry_gap", 8'(entry_at - exit_at), 8'd4);

    // Full lot holds the entry until is_full drops
    do_reset();
    is_full = 1;
    mark();
    entry_raw = 1;
    ticks(8);
    entry_raw = 0;
    ticks(12);
    check_eq("t4_held", 8'(n_entry), 8'd0);
    mark();
    is_full = 0;
    ticks(6);
    check_eq("t4_release_at", 8'(entry_at), 8'd1);

    // Exit from an empty slot is rejected
    do_reset();
    mark();
    spots = 4'b0111; slot_raw = 2'd3;
    exit_raw = 1;
    ticks(8);
    exit_raw = 0;
    ticks(8);
    check_eq("t5_rejected_at", 8'(rej_at), 8'd8);
    check_eq("t5_no_exit", 8'(n_exit), 8'd0);

    // Reset while an entry is pending aborts it
    do_reset();
    mark();
    entry_raw = 1;
    ticks(6);
    reset = 1; entry_raw = 0;
    tick();
    check_eq("t6_in_reset", {entry_signal, exit_signal, rejected, overrun}, 4'd0);
    tick();
    reset = 0;
    ticks(15);
    check_eq("t6_no_pulse", 8'(n_entry), 8'd0);

    // Random traffic against the model
    do_reset();
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1;
        ticks($urandom_range(1, 2));
        reset = 0;
      end
      if ($urandom_range(0, 2) == 0) entry_raw = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) exit_raw = $urandom_range(0, 1);
      slot_raw = 2'($urandom_range(0, 3));
      spots = 4'($urandom_range(0, 15));
      is_full = ($urandom_range(0, 3) == 0);
      ticks($urandom_range(1, 9));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
